// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the MULT/DIV scheduler state encoding.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] MFHI   = 6'h10;
  localparam logic [5:0] MFLO   = 6'h12;
  localparam logic [5:0] MULT   = 6'h18;
  localparam logic [5:0] MULTU  = 6'h19;
  localparam logic [5:0] DIV    = 6'h1A;
  localparam logic [5:0] DIVU   = 6'h1B;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic op_sign_ext(input logic [5:0] op);
    return !(op == ANDI || op == ORI || op == XORI || op == LUI);
  endfunction

endpackage

// File: rtl/md_scheduler.sv
// Occupancy tracker for the shared multi-cycle MULT/DIV unit: IDLE/BUSY FSM,
// latency countdown, busy flag and registered done pulse.
module md_scheduler
  import mips_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sel_div,
  output logic busy,
  output logic done
);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = sel_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Busy drops immediately while reset is held so a held MFHI/MFLO is released.
  assign busy = rst_n && (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline sequencer: immediate extension select, load-use and MULT/DIV
// stalls, branch flushes. Optional counters under HAZARD_PERF_EN.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_op,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        ext_sign,
  output logic        md_start,
  output logic        md_busy,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        md_done
);

  logic is_rtype, is_md, is_mf, uses_rt;
  logic load_use, md_stall;

  assign is_rtype = (id_op == R_TYPE);
  assign is_md    = is_rtype && (id_funct == MULT || id_funct == MULTU ||
                                 id_funct == DIV  || id_funct == DIVU);
  assign is_mf    = is_rtype && (id_funct == MFHI || id_funct == MFLO);
  assign uses_rt  = is_rtype || (id_op == BEQ) || (id_op == SW);

  assign ext_sign = op_sign_ext(id_op);

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  assign md_stall = (is_mf || is_md) && md_busy;

  // md_busy already gates on BUSY, so !md_busy doubles as "scheduler idle".
  assign md_start = rst_n && is_md && !md_busy && !ex_branch_taken && !load_use;

  md_scheduler #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_scheduler (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_start),
    .sel_div (id_funct[1]),
    .busy    (md_busy),
    .done    (md_done)
  );

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || md_stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_we && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (ex_branch_taken && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; control vector order is
// {pc_we, ifid_we, ifid_flush, idex_flush, md_start, md_busy, md_done}.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, ex_branch_taken;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, ext_sign;
  logic        md_start, md_busy, md_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_op           (id_op),
    .id_funct        (id_funct),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .ext_sign        (ext_sign),
    .md_start        (md_start),
    .md_busy         (md_busy),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .md_done         (md_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] C_RST   = 7'b0011000;
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b1111000;
  localparam logic [6:0] C_START = 7'b1100100;
  localparam logic [6:0] C_MDSTL = 7'b0001010;
  localparam logic [6:0] C_BUSY  = 7'b1100010;
  localparam logic [6:0] C_DONE  = 7'b1100001;
  localparam logic [6:0] C_B2B   = 7'b1100101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, pc_we, ifid_we, ifid_flush, idex_flush, md_start, md_busy, md_done},
        {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                       input logic br);
    id_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
    ex_memread = mr; ex_rt = xrt; ex_branch_taken = br;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk_ctl("reset_comb", C_RST);
    tick(); tick();
    chk_ctl("reset_held", C_RST);

    rst_n = 1'b1;
    chk_ctl("run_nop", C_RUN);

    // load-use on rs: ADD rs=2 behind LW $2
    drive(6'h00, 6'h20, 5'd2, 5'd3, 1'b1, 5'd2, 1'b0);
    chk_ctl("lu_rs_stall", C_STALL);
    tick();
    drive(6'h00, 6'h20, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
    chk_ctl("lu_rs_release", C_RUN);

    drive(6'h00, 6'h20, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    chk_ctl("lu_r0_nostall", C_RUN);
    drive(6'h2B, 6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
    chk_ctl("lu_sw_rt", C_STALL);
    drive(6'h08, 6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0);
    chk_ctl("lu_addi_rt_ignored", C_RUN);

    drive(6'h0D, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); #1; chk("ext_ori", {31'd0, ext_sign}, 32'd0);
    drive(6'h04, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); #1; chk("ext_beq", {31'd0, ext_sign}, 32'd1);
    drive(6'h0F, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); #1; chk("ext_lui", {31'd0, ext_sign}, 32'd0);
    drive(6'h0C, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); #1; chk("ext_andi", {31'd0, ext_sign}, 32'd0);
    drive(6'h23, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); #1; chk("ext_lw", {31'd0, ext_sign}, 32'd1);
    drive(6'h0A, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); #1; chk("ext_slti", {31'd0, ext_sign}, 32'd1);

    // branch beats load-use and cancels the MULTU start
    drive(6'h00, 6'h19, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1);
    chk_ctl("branch_prio", C_BR);
    tick();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk_ctl("branch_no_start", C_RUN);

    // MULTU then MFHI
    drive(6'h00, 6'h19, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0);
    chk_ctl("multu_start", C_START);
    tick();
    drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk_ctl($sformatf("mfhi_stall_%0d", i), C_MDSTL);
      tick();
    end
    chk_ctl("mfhi_issue_done", C_DONE);
    tick();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk_ctl("after_done", C_RUN);

    // back-to-back MULT: second one waits, starts on the IDLE cycle
    drive(6'h00, 6'h18, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0);
    chk_ctl("mult1_start", C_START);
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      chk_ctl($sformatf("mult2_stall_%0d", i), C_MDSTL);
      tick();
    end
    chk_ctl("mult2_start_done", C_B2B);
    tick();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk_ctl($sformatf("mult2_busy_%0d", i), C_BUSY);
      tick();
    end
    chk_ctl("mult2_done", C_DONE);
    tick();

    // DIVU aborted by reset after 10 busy cycles
    drive(6'h00, 6'h1B, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0);
    chk_ctl("divu_start", C_START);
    tick();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      chk_ctl($sformatf("divu_busy_%0d", i), C_BUSY);
      tick();
    end
    rst_n = 1'b0;
    chk_ctl("divu_reset_comb", C_RST);
    tick();
    chk_ctl("divu_reset_edge", C_RST);
    rst_n = 1'b1;
    drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk_ctl("post_abort_mflo", C_RUN);
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int unsigned i = 0; i < 30; i++) begin
      tick();
      chk_ctl($sformatf("no_done_%0d", i), C_RUN);
    end

`ifdef HAZARD_PERF_EN
    rst_n = 1'b0;
    tick();
    #1; chk("perf_stall_clr", perf_stall_cnt, 32'd0);
    chk("perf_flush_clr", perf_flush_cnt, 32'd0);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(6'h00, 6'h20, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0);
      tick();
      drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    for (int unsigned i = 0; i < 2; i++) begin
      drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
      tick();
      drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core, located at the ID stage beside sign_extend.
- Selects the immediate-extension mode and detects load-use hazards.
- Issues stall and flush controls to PC, IF/ID and ID/EX.
- Schedules the shared multi-cycle MULT/DIV unit, holding MFHI/MFLO in ID until HI/LO are valid.

Parameters:
- MUL_LAT, 4, cycles MULT/MULTU occupies the md unit (>=2).
- DIV_LAT, 32, cycles DIV/DIVU occupies the md unit (>=2).
- CNT_W, 6, md countdown width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- id_op  in  6  opcode of the instruction in ID.
- id_funct  in  6  funct field of the instruction in ID.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- ex_memread  in  1  instruction in EX is LW.
- ex_rt  in  5  destination of the LW in EX.
- ex_branch_taken  in  1  BEQ resolved taken in EX.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  zero the IF/ID register.
- idex_flush  out  1  insert a bubble into ID/EX.
- ext_sign  out  1  1 = sign-extend immediate, 0 = zero-extend (drives the sign_extend select).
- md_start  out  1  one-cycle start pulse to the MULT/DIV unit.
- md_busy  out  1  MULT/DIV unit occupied.
- md_done  out  1  registered one-cycle pulse when HI/LO become valid.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- While rst_n=0 (sampled at posedge):
  - pc_we=0, ifid_we=0.
  - ifid_flush=1, idex_flush=1.
  - md_start=0, md_busy=0, md_done=0.
  - State goes to IDLE, count=0.
- ext_sign (combinational):
  - 0 for ANDI(0x0C), ORI(0x0D), XORI(0x0E), LUI(0x0F).
  - 1 otherwise, including BEQ(4), LW(35), SW(43), ADDI(8), SLTI(10).
- Decode groups (id_op=0):
  - is_md: funct MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - is_mf: funct MFHI 0x10, MFLO 0x12.
- uses_rt is true for R-type, BEQ and SW.
- load_use = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (uses_rt && ex_rt==id_rt)).
- md_stall = (is_mf || is_md) && md_busy.
- Control priority, evaluated in this order each cycle:
  1. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_we=1, ifid_we=1. Any stall is cancelled and md_start=0.
  2. load_use or md_stall: pc_we=0, ifid_we=0, idex_flush=1, ifid_flush=0.
  3. Otherwise: pc_we=1, ifid_we=1, both flushes=0.
- md_start=1 only when is_md, state=IDLE, no branch flush and no load_use.
- FSM IDLE:
  - On md_start, go to BUSY.
  - Load count with MUL_LAT-1 if funct[1]=0 (MULT/MULTU), else DIV_LAT-1.
- FSM BUSY:
  - md_busy=1; count decrements each cycle.
  - When count==0, go to IDLE and pulse md_done=1 on the next cycle.
  - Back-to-back md ops: a second is_md in ID during BUSY stalls and starts on the first IDLE cycle.
  - md_busy is 0 in the cycle after the last BUSY cycle, so MFHI issues then.
- Reset mid-BUSY aborts the operation; no md_done is generated.
- id_rs/id_rt equal to 0 never cause a load-use stall.
- All control outputs other than md_done are combinational from inputs and registered state, with no added latency.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds two outputs:
  - perf_stall_cnt (32): increments on each cycle with pc_we=0 and rst_n=1.
  - perf_flush_cnt (32): increments on each cycle with ex_branch_taken=1.
  - Both saturate at 0xFFFFFFFF and are cleared by reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: R_TYPE, BEQ=4, LW=35, SW=43, ADDI, ANDI, ORI, XORI, LUI, SLTI.
  - Funct constants: MULT, MULTU, DIV, DIVU, MFHI, MFLO.
  - md FSM state encoding: IDLE, BUSY.
- One sub-module, md_scheduler, contains the IDLE/BUSY FSM, countdown, md_busy and md_done.
- Hazard and priority logic stays in hazard_ctrl.

Test Plan:
- LW $2 in EX (ex_memread=1, ex_rt=2), ADD rs=2 in ID -> one cycle pc_we=0, ifid_we=0, idex_flush=1. Next cycle (ex_memread=0) -> pc_we=1.
- ex_memread=1, ex_rt=0, id_rs=0 -> no stall. ORI in ID -> ext_sign=0; BEQ -> ext_sign=1.
- ex_branch_taken=1 together with load_use and MULTU in ID -> ifid_flush=1, idex_flush=1, pc_we=1, md_start=0.
- MULTU (MUL_LAT=4) then MFHI -> md_start pulse; MFHI stalls while md_busy=1 for 4 cycles; md_done pulses; MFHI issues the following cycle.
- DIVU started, rst_n=0 asserted after 10 busy cycles -> md_busy=0 on the next edge, no md_done; after release, state is IDLE and pc_we=1.
- With HAZARD_PERF_EN: three load-use stalls and two taken branches -> perf_stall_cnt=3, perf_flush_cnt=2.
